ltc229x_capture: RTL and testbench
==================================

# ltc229x_capture

Parametrised capture front-end for the LTC2290/2291/2292 dual 10/12/14-bit ADC family. Supports multiplexed and separate output buses, offset-binary or two's-complement coding, and the ADC overflow pin. Delivers clk-aligned signed samples for channel A and channel B with a data-valid flag that masks the ADC pipeline warm-up, plus per-channel overrange reporting. Sits directly behind the ADC pins and feeds the DSP chain.

## Interface
- `WIDTH`, 12: sample width; legal values 10, 12, 14.
- `MUX`, "TRUE": "TRUE" means A and B share `di_a` and `of_a`; "FALSE" means separate `di_a`/`di_b` and `of_a`/`of_b`.
- `FORMAT`, "TWOS": input coding; "TWOS" or "OFFSET".
- `WARMUP`, 5: ADC pipeline latency, in clk cycles, to discard after (re)start; range 0–255.
- `CNT_W`, 16: overrange counter width.
- `clk` in 1: ADC sample clock; the only clock.
- `rst` in 1: synchronous reset, active-high, sampled on the rising edge of `clk`.
- `en` in 1: capture enable.
- `di_a` in WIDTH: ADC bus A, or the multiplexed bus.
- `di_b` in WIDTH: ADC bus B; ignored when MUX="TRUE".
- `of_a` in 1: overflow pin A, or the multiplexed OF.
- `of_b` in 1: overflow pin B; ignored when MUX="TRUE".
- `ovr_clr` in 1: clears sticky flags and counters.
- `dao` out WIDTH: channel A sample, signed.
- `dbo` out WIDTH: channel B sample, signed.
- `dv` out 1: `dao`/`dbo` are valid this cycle.
- `ova`, `ovb` out 1: overrange flag aligned with `dao`/`dbo`.
- `ovr_sticky` out 2: {B,A} latched overrange.
- `ovr_cnt_a`, `ovr_cnt_b` out CNT_W: saturating overrange event counts.

## Operation
- **Capture stage, MUX="TRUE":**
  - Channel A (data and OF) is sampled on the falling edge of `clk` into an A holding register.
  - Channel B is sampled on the rising edge.
  - On each rising edge, stage-1 loads {A holding register, `di_a`, `of_a`}.
- **Capture stage, MUX="FALSE":** both channels are sampled into stage-1 on the rising edge.
- **Format stage (rising edge):**
  - FORMAT="OFFSET": invert the MSB.
  - FORMAT="TWOS": pass through unchanged.
  - Results load `dao`/`dbo`/`ova`/`ovb`. No width change, no saturation.
- **Control FSM states:**
  - IDLE: `en`=0. Outputs hold their last value and `dv`=0.
  - WARM: counting. `dv`=0.
  - RUN: `dv`=1.
- **FSM transitions:**
  - IDLE→WARM when `en`=1; the warm counter is cleared.
  - WARM→RUN when the counter reaches WARMUP+2, which covers the ADC latency plus the 2 internal stages.
  - WARMUP=0 still needs 2 cycles in WARM.
  - Any state→IDLE when `en`=0, taking effect the same cycle; `dv` falls at the next edge.
- **Overrange:**
  - Evaluated only when `dv` would be 1, i.e. in RUN.
  - `ova`=1 sets `ovr_sticky[0]` and increments `ovr_cnt_a`; the counter saturates at 2^CNT_W−1 and never wraps. `ovb` does the same for bit 1 and `ovr_cnt_b`.
  - `ovr_clr` zeroes both flags and both counters.
  - An event in the same cycle as `ovr_clr` wins: the flag ends at 1 and the counter at 1.
- **Reset:**
  - `dao`, `dbo`, `ova`, `ovb`, `dv`, `ovr_sticky`, `ovr_cnt_*` are 0; stage-1 is 0; FSM is in IDLE.
  - The falling-edge A holding register is not reset.
  - Reset mid-run drops `dv` on the next rising edge, and a full warm-up is required afterwards.

## Timing
- Latency is 2 rising edges:
  - The B sample captured at rising edge n appears on `dbo` after rising edge n+1.
  - The A sample captured at the falling edge between n−1 and n appears on `dao` after rising edge n+1, paired with that B sample.
- Throughput is 1 A/B pair per clk. `dv` has no backpressure; downstream must accept every cycle.
- After `en` rises at edge e (seen by the FSM at e), the first `dv`=1 is after edge e+WARMUP+3.
- Sticky flags and counters update 1 edge after the `ova`/`ovb` they reflect.

## Structure
- `ltc229x_pkg`:
  - FSM state enum (IDLE, WARM, RUN).
  - FORMAT string constants.
  - A `WIDTH` legality check function.
- Sub-module `ltc229x_ovr_cnt` (saturating counter with clear-vs-increment priority), instantiated once per channel.
- FSM, capture and format logic stay in the top level.

## Test plan
- **MUX="TRUE", WIDTH=12, TWOS, WARMUP=5:** `en`=1 after reset; A=0x123 driven at falling edges, B=0xEDC at rising edges → `dv`=0 for 7 cycles, then `dao`=0x123 and `dbo`=0xEDC, with 2-edge latency checked against a scoreboard.
- **FORMAT="OFFSET", WIDTH=14:** input 0x0000 → output 0x2000 (−8192); input 0x3FFF → 0x1FFF; input 0x2000 → 0.
- **MUX="FALSE", WIDTH=10:** independent ramps on `di_a`/`di_b` → both appear on the same edge with no cross-channel mixing.
- **Overrange:** `of_a` high for 3 RUN cycles, then `ovr_clr` coinciding with a 4th event → counter ends at 1 and `ovr_sticky`=2'b01. CNT_W=4 with 20 events → counter holds at 15.
- **`en` drop mid-run:** `en` low for 1 cycle, then high → `dv` low for WARMUP+3 cycles and outputs hold while in IDLE.
- **`rst` asserted mid-run:** all outputs are 0 after the next edge, and warm-up restarts in full.

Source files
------------

// File: rtl/ltc229x_pkg.sv
// Shared types and constants for the LTC229x dual-ADC capture front-end.
// Holds the control FSM encoding, FORMAT/MUX strings and the width check.
package ltc229x_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WARM,
        RUN
    } state_t;

    localparam string FMT_TWOS   = "TWOS";
    localparam string FMT_OFFSET = "OFFSET";
    localparam string MUX_ON     = "TRUE";

    function automatic bit width_ok(input int w);
        return (w == 10) || (w == 12) || (w == 14);
    endfunction

endpackage

// File: rtl/ltc229x_ovr_cnt.sv
// Saturating overrange event counter.
// A clear coinciding with an event leaves the count at one.
module ltc229x_ovr_cnt
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= CNT_W'(inc);
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ltc229x_capture.sv
// LTC2290/1/2 capture: demux, format conversion, warm-up masking
// and per-channel overrange reporting, all in the ADC clock domain.
module ltc229x_capture
    import ltc229x_pkg::*;
#(
    parameter int    WIDTH  = 12,
    parameter string MUX    = "TRUE",
    parameter string FORMAT = "TWOS",
    parameter int    WARMUP = 5,
    parameter int    CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] di_a,
    input  logic [WIDTH-1:0] di_b,
    input  logic             of_a,
    input  logic             of_b,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] dao,
    output logic [WIDTH-1:0] dbo,
    output logic             dv,
    output logic             ova,
    output logic             ovb,
    output logic [1:0]       ovr_sticky,
    output logic [CNT_W-1:0] ovr_cnt_a,
    output logic [CNT_W-1:0] ovr_cnt_b
);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("ltc229x_capture: WIDTH must be 10, 12 or 14");
    end

    localparam logic [8:0] WARM_END = 9'(WARMUP + 2);

    state_t           state;
    state_t           state_nx;
    logic [8:0]       wcnt;
    logic             load;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic             cap_oa;
    logic             cap_ob;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_oa;
    logic             s1_ob;
    logic             ev_a;
    logic             ev_b;

    function automatic logic [WIDTH-1:0] fmt(input logic [WIDTH-1:0] x);
        if (FORMAT == FMT_OFFSET) begin
            return {~x[WIDTH-1], x[WIDTH-2:0]};
        end
        return x;
    endfunction

    // Multiplexed bus: A is presented around the falling edge, B around the rising edge.
    if (MUX == MUX_ON) begin : g_mux
        logic [WIDTH-1:0] a_hold;
        logic             a_hold_of;
        logic             unused_b;

        always_ff @(negedge clk) begin
            a_hold    <= di_a;
            a_hold_of <= of_a;
        end

        assign cap_a    = a_hold;
        assign cap_oa   = a_hold_of;
        assign cap_b    = di_a;
        assign cap_ob   = of_a;
        assign unused_b = ^{di_b, of_b};
    end else begin : g_sep
        assign cap_a  = di_a;
        assign cap_oa = of_a;
        assign cap_b  = di_b;
        assign cap_ob = of_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (!en) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_nx = WARM;
                WARM:    if (wcnt == WARM_END) state_nx = RUN;
                default: state_nx = RUN;
            endcase
        end
    end

    always_comb begin
        dv   = 1'b0;
        load = 1'b1;
        unique case (state)
            IDLE:    load = 1'b0;
            RUN:     dv   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || (state != WARM)) begin
            wcnt <= '0;
        end else begin
            wcnt <= wcnt + 9'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_a  <= '0;
            s1_b  <= '0;
            s1_oa <= 1'b0;
            s1_ob <= 1'b0;
        end else begin
            s1_a  <= cap_a;
            s1_b  <= cap_b;
            s1_oa <= cap_oa;
            s1_ob <= cap_ob;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dao <= '0;
            dbo <= '0;
            ova <= 1'b0;
            ovb <= 1'b0;
        end else if (load) begin
            dao <= fmt(s1_a);
            dbo <= fmt(s1_b);
            ova <= s1_oa;
            ovb <= s1_ob;
        end
    end

    assign ev_a = dv & ova;
    assign ev_b = dv & ovb;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_sticky <= 2'b00;
        end else if (ovr_clr) begin
            ovr_sticky <= {ev_b, ev_a};
        end else begin
            ovr_sticky <= ovr_sticky | {ev_b, ev_a};
        end
    end

    ltc229x_ovr_cnt #(.CNT_W(CNT_W)) u_cnt_a (
        .clk (clk),
        .rst (rst),
        .clr (ovr_clr),
        .inc (ev_a),
        .cnt (ovr_cnt_a)
    );

    ltc229x_ovr_cnt #(.CNT_W(CNT_W)) u_cnt_b (
        .clk (clk),
        .rst (rst),
        .clr (ovr_clr),
        .inc (ev_b),
        .cnt (ovr_cnt_b)
    );

endmodule

// File: tb/tb_ltc229x_capture.sv
// Directed bench: multiplexed 12-bit TWOS instance and separate-bus
// 14-bit OFFSET instance sharing clock, reset, enable and clear.
module tb_ltc229x_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        ovr_clr = 1'b0;

    logic [11:0] di_a0 = '0;
    logic [11:0] di_b0 = '0;
    logic        of_a0 = 1'b0;
    logic        of_b0 = 1'b0;
    logic [11:0] dao0, dbo0;
    logic        dv0, ova0, ovb0;
    logic [1:0]  stk0;
    logic [3:0]  cnta0, cntb0;

    logic [13:0] di_a1 = '0;
    logic [13:0] di_b1 = '0;
    logic        of_a1 = 1'b0;
    logic        of_b1 = 1'b0;
    logic [13:0] dao1, dbo1;
    logic        dv1, ova1, ovb1;
    logic [1:0]  stk1;
    logic [15:0] cnta1, cntb1;

    int errors = 0;
    int checks = 0;

    logic [11:0] av [5] = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555};
    logic [11:0] bv [5] = '{12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD, 12'hEEE};
    logic [13:0] ia [5] = '{14'h0000, 14'h3FFF, 14'h2000, 14'h1234, 14'h0000};
    logic [13:0] ib [5] = '{14'h1000, 14'h2ABC, 14'h3FFE, 14'h0001, 14'h0000};
    logic [13:0] ea [4] = '{14'h2000, 14'h1FFF, 14'h0000, 14'h3234};
    logic [13:0] eb [4] = '{14'h3000, 14'h0ABC, 14'h1FFE, 14'h2001};

    always #5 clk = ~clk;

    ltc229x_capture #(
        .WIDTH(12), .MUX("TRUE"), .FORMAT("TWOS"), .WARMUP(5), .CNT_W(4)
    ) u0 (
        .clk(clk), .rst(rst), .en(en),
        .di_a(di_a0), .di_b(di_b0), .of_a(of_a0), .of_b(of_b0),
        .ovr_clr(ovr_clr),
        .dao(dao0), .dbo(dbo0), .dv(dv0), .ova(ova0), .ovb(ovb0),
        .ovr_sticky(stk0), .ovr_cnt_a(cnta0), .ovr_cnt_b(cntb0)
    );

    ltc229x_capture #(
        .WIDTH(14), .MUX("FALSE"), .FORMAT("OFFSET"), .WARMUP(0), .CNT_W(16)
    ) u1 (
        .clk(clk), .rst(rst), .en(en),
        .di_a(di_a1), .di_b(di_b1), .of_a(of_a1), .of_b(of_b1),
        .ovr_clr(ovr_clr),
        .dao(dao1), .dbo(dbo1), .dv(dv1), .ova(ova1), .ovb(ovb1),
        .ovr_sticky(stk1), .ovr_cnt_a(cnta1), .ovr_cnt_b(cntb1)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge: A goes out before the falling edge, B before the rising edge.
    task automatic pair(input logic [11:0] a, input logic oa,
                        input logic [11:0] b, input logic ob);
        di_a0 = a;
        of_a0 = oa;
        @(negedge clk);
        #1;
        di_a0 = b;
        of_a0 = ob;
        @(posedge clk);
        #1;
    endtask

    // Edges e+1 .. e+8 after the edge e that first sees en=1.
    task automatic warm_rest(input string tag, input logic [11:0] a,
                             input logic [11:0] b);
        for (int i = 1; i <= 8; i++) begin
            pair(a, 1'b0, b, 1'b0);
            check({tag, "_dv0"}, 32'(dv0), 32'(i == 8));
            check({tag, "_dv1"}, 32'(dv1), 32'(i >= 3));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        pair(12'h000, 1'b0, 12'h000, 1'b0);
        pair(12'h000, 1'b0, 12'h000, 1'b0);
        check("rst_dao", 32'(dao0), 32'h0);
        check("rst_dbo", 32'(dbo0), 32'h0);
        check("rst_dv", 32'(dv0), 32'h0);
        check("rst_stk", 32'(stk0), 32'h0);
        check("rst_cnt", 32'(cnta0), 32'h0);
        check("rst_dao1", 32'(dao1), 32'h0);

        rst = 1'b0;
        en  = 1'b1;
        pair(12'h123, 1'b0, 12'hEDC, 1'b0);
        check("warm0_dv", 32'(dv0), 32'h0);
        warm_rest("warm", 12'h123, 12'hEDC);
        check("run_dao", 32'(dao0), 32'h123);
        check("run_dbo", 32'(dbo0), 32'hEDC);

        for (int k = 0; k < 5; k++) begin
            di_a1 = ia[k];
            di_b1 = ib[k];
            of_b1 = (k == 1);
            pair(av[k], 1'b0, bv[k], 1'b0);
            if (k > 0) begin
                check("lat_dao", 32'(dao0), 32'(av[k-1]));
                check("lat_dbo", 32'(dbo0), 32'(bv[k-1]));
                check("ofs_dao", 32'(dao1), 32'(ea[k-1]));
                check("ofs_dbo", 32'(dbo1), 32'(eb[k-1]));
                check("sep_ova", 32'(ova1), 32'h0);
                check("sep_ovb", 32'(ovb1), 32'(k == 2));
            end
        end
        of_b1 = 1'b0;

        pair(12'h100, 1'b1, 12'h200, 1'b0);
        pair(12'h100, 1'b1, 12'h200, 1'b0);
        check("ova_align", 32'(ova0), 32'h1);
        check("ovb_quiet", 32'(ovb0), 32'h0);
        pair(12'h100, 1'b1, 12'h200, 1'b0);
        pair(12'h100, 1'b1, 12'h200, 1'b0);
        pair(12'h100, 1'b0, 12'h200, 1'b0);
        check("ovr_cnt3", 32'(cnta0), 32'h3);
        check("ovr_stk3", 32'(stk0), 32'h1);
        ovr_clr = 1'b1;
        pair(12'h100, 1'b0, 12'h200, 1'b0);
        ovr_clr = 1'b0;
        check("clr_cnt", 32'(cnta0), 32'h1);
        check("clr_stk", 32'(stk0), 32'h1);
        pair(12'h100, 1'b0, 12'h200, 1'b0);
        check("post_cnt", 32'(cnta0), 32'h1);
        check("post_cntb", 32'(cntb0), 32'h0);

        for (int k = 1; k <= 22; k++) begin
            pair(12'h100, 1'b0, 12'h200, k <= 20);
            if (k == 16) check("sat_cnt14", 32'(cntb0), 32'd14);
        end
        check("sat_cnt15", 32'(cntb0), 32'd15);
        check("sat_stk", 32'(stk0), 32'h3);
        check("sat_cnta", 32'(cnta0), 32'h1);

        pair(12'h5A5, 1'b0, 12'hA5A, 1'b0);
        pair(12'h5A5, 1'b0, 12'hA5A, 1'b0);
        en = 1'b0;
        pair(12'h0F0, 1'b0, 12'h0F0, 1'b0);
        check("endrop_dv", 32'(dv0), 32'h0);
        check("endrop_dao", 32'(dao0), 32'h5A5);
        en = 1'b1;
        pair(12'h0F0, 1'b0, 12'h0F0, 1'b0);
        check("hold_dao", 32'(dao0), 32'h5A5);
        check("hold_dbo", 32'(dbo0), 32'hA5A);
        check("hold_dv", 32'(dv0), 32'h0);
        warm_rest("rewarm", 12'h0F0, 12'h0F0);
        check("rewarm_dao", 32'(dao0), 32'h0F0);

        rst = 1'b1;
        pair(12'h321, 1'b0, 12'h654, 1'b0);
        check("mrst_dao", 32'(dao0), 32'h0);
        check("mrst_dbo", 32'(dbo0), 32'h0);
        check("mrst_dv", 32'(dv0), 32'h0);
        check("mrst_stk", 32'(stk0), 32'h0);
        check("mrst_cntb", 32'(cntb0), 32'h0);
        check("mrst_dv1", 32'(dv1), 32'h0);
        check("mrst_cntb1", 32'(cntb1), 32'h0);
        rst = 1'b0;
        pair(12'h321, 1'b0, 12'h654, 1'b0);
        check("mrst_warm0", 32'(dv0), 32'h0);
        warm_rest("mrst", 12'h321, 12'h654);
        check("mrst_run_dao", 32'(dao0), 32'h321);
        check("mrst_run_dbo", 32'(dbo0), 32'h654);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
